// File: rtl/i2c_target_mem.sv
// I2C target with a pointer-addressed byte memory that auto-increments; it decodes START, STOP and the bus address.
// Bus events act 3 clk_i cycles after a pin change; the target never stretches SCL.
`timescale 1ns/1ps
module i2c_target_mem #(
   parameter logic [6:0] SLAVE_ADDR = 7'h22,
   parameter int         MEM_DEPTH  = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         scl_i,
   input  logic                         sda_i,
   output logic                         sda_oe_o,
   output logic                         busy_o,
   output logic                         sel_o,
   output logic                         wr_stb_o,
   output logic [$clog2(MEM_DEPTH)-1:0] wr_addr_o,
   output logic [7:0]                   wr_data_o
);
   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      scl_q, scl_d, sda_q, sda_d;
   logic [7:0]      shift_q, shift_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic            sda_oe_q, sda_oe_d, busy_q, busy_d, sel_q, sel_d, wr_stb_q, wr_stb_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [7:0]      wr_data_q, wr_data_d;
   logic [7:0]      mem_q [MEM_DEPTH];
   logic [7:0]      mem_d [MEM_DEPTH];

   logic scl_rise, scl_fall, start_det, stop_det, sda_bit, last_bit, ack_done;
   logic [7:0] shift_in;

   // Bits [1:0] synchronize the pins; bit 2 holds the previous synchronized sample.
   assign scl_d     = {scl_q[1:0], scl_i};
   assign sda_d     = {sda_q[1:0], sda_i};
   assign scl_rise  =  scl_q[1] & ~scl_q[2];
   assign scl_fall  = ~scl_q[1] &  scl_q[2];
   assign start_det =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
   assign stop_det  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];
   assign sda_bit   = sda_q[1];
   assign shift_in  = {shift_q[6:0], sda_bit};
   assign last_bit  = (cnt_q == 4'd7);
   // An ACK slot drives on its first falling edge and finishes on the next one.
   assign ack_done  = scl_fall & sda_oe_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (stop_det)       state_d = S_IDLE;
      else if (start_det) state_d = S_ADDR;
      else begin
         case (state_q)
            S_ADDR:      if (scl_rise && last_bit)
                            state_d = (shift_in[7:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_IGNORE;
            S_ADDR_ACK:  if (ack_done) state_d = shift_q[0] ? S_RDATA : S_PTR;
            S_PTR:       if (scl_rise && last_bit) state_d = S_PTR_ACK;
            S_PTR_ACK:   if (ack_done) state_d = S_WDATA;
            S_WDATA:     if (scl_rise && last_bit) state_d = S_WDATA_ACK;
            S_WDATA_ACK: if (ack_done) state_d = S_WDATA;
            S_RDATA:     if (scl_fall && cnt_q == 4'd8) state_d = S_RACK;
            S_RACK: begin
               if (scl_rise && sda_bit) state_d = S_IGNORE;
               else if (scl_fall)       state_d = S_RDATA;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      sda_oe_d  = sda_oe_q;
      busy_d    = busy_q;
      sel_d     = sel_q;
      wr_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      mem_d     = mem_q;
      if (stop_det) begin
         busy_d   = 1'b0;
         sel_d    = 1'b0;
         sda_oe_d = 1'b0;
      end else if (start_det) begin
         busy_d   = 1'b1;
         sel_d    = 1'b0;
         sda_oe_d = 1'b0;
         cnt_d    = '0;
      end else begin
         case (state_q)
            S_ADDR, S_PTR, S_WDATA: if (scl_rise) begin
               shift_d = shift_in;
               cnt_d   = cnt_q + 4'd1;
               if (last_bit) begin
                  cnt_d = '0;
                  if (state_q == S_ADDR) sel_d = (shift_in[7:1] == SLAVE_ADDR);
                  if (state_q == S_PTR)  ptr_d = shift_in[AW-1:0];
                  if (state_q == S_WDATA) begin
                     mem_d[ptr_q] = shift_in;
                     wr_stb_d     = 1'b1;
                     wr_addr_d    = ptr_q;
                     wr_data_d    = shift_in;
                     ptr_d        = ptr_q + 1'b1;
                  end
               end
            end
            S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
               if (!sda_oe_q) sda_oe_d = 1'b1;
               else begin
                  cnt_d    = '0;
                  sda_oe_d = 1'b0;
                  if (state_q == S_ADDR_ACK && shift_q[0]) begin
                     shift_d  = mem_q[ptr_q];
                     ptr_d    = ptr_q + 1'b1;
                     sda_oe_d = ~mem_q[ptr_q][7];
                  end
               end
            end
            S_RDATA: begin
               if (scl_rise) cnt_d = cnt_q + 4'd1;
               else if (scl_fall) begin
                  if (cnt_q == 4'd8) sda_oe_d = 1'b0;
                  else begin
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                  end
               end
            end
            S_RACK: begin
               if (scl_rise && !sda_bit) begin
                  shift_d = mem_q[ptr_q];
                  ptr_d   = ptr_q + 1'b1;
                  cnt_d   = '0;
               end else if (scl_fall) begin
                  sda_oe_d = ~shift_q[7];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         scl_q     <= 3'b111;
         sda_q     <= 3'b111;
         shift_q   <= '0;
         cnt_q     <= '0;
         ptr_q     <= '0;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         sel_q     <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         scl_q     <= scl_d;
         sda_q     <= sda_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         sda_oe_q  <= sda_oe_d;
         busy_q    <= busy_d;
         sel_q     <= sel_d;
         wr_stb_q  <= wr_stb_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         mem_q     <= mem_d;
      end
   end

   assign sda_oe_o  = sda_oe_q;
   assign busy_o    = busy_q;
   assign sel_o     = sel_q;
   assign wr_stb_o  = wr_stb_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;
endmodule

// File: tb/tb_i2c_target_mem.sv
// Directed I2C controller model driving an open-drain bus into i2c_target_mem.
// The model issues writes, reads, repeated starts, aborts and a reset pulsed during a read.
`timescale 1ns/1ps
module tb_i2c_target_mem;
   localparam int Q = 80;

   logic       clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
   logic       sda_oe, busy, sel, wr_stb, sda_line;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   int         checks = 0, failures = 0;
   int         wr_log[$];
   logic       oe_seen = 1'b0;

   assign sda_line = sda_m & ~sda_oe;
   always #5 clk = ~clk;

   i2c_target_mem #(.SLAVE_ADDR(7'h22), .MEM_DEPTH(16)) dut (
      .clk_i(clk), .rst_i(rst), .scl_i(scl_m), .sda_i(sda_line),
      .sda_oe_o(sda_oe), .busy_o(busy), .sel_o(sel), .wr_stb_o(wr_stb),
      .wr_addr_o(wr_addr), .wr_data_o(wr_data)
   );

   always @(negedge clk) begin
      if (wr_stb) wr_log.push_back(int'({wr_addr, wr_data}));
      if (sda_oe) oe_seen = 1'b1;
   end

   task automatic bus_start();
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         sda_m = b[i]; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      send_bits(b, 8);
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; ack = ~sda_line; #Q; scl_m = 1'b0; #Q;
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] b);
      sda_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         #Q; scl_m = 1'b1; #Q; b[i] = sda_line; #Q; scl_m = 1'b0; #Q;
      end
      sda_m = ~mack; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q; sda_m = 1'b1;
   endtask

   task automatic write_seq(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1,
                            input int nd, output int acks);
      logic a;
      acks = 0;
      bus_start();
      send_byte(8'h44, a); if (a) acks++;
      send_byte(p, a);     if (a) acks++;
      send_byte(d0, a);    if (a) acks++;
      if (nd > 1) begin send_byte(d1, a); if (a) acks++; end
      bus_stop();
   endtask

   task automatic test_reset();
      #23;
      checks++; if (sda_oe !== 1'b0)  begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
      checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (sel !== 1'b0)     begin failures++; $display("FAIL reset_sel got=%b exp=0", sel); end
      checks++; if (wr_stb !== 1'b0)  begin failures++; $display("FAIL reset_wr_stb got=%b exp=0", wr_stb); end
      checks++; if (wr_addr !== 4'h0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
      checks++; if (wr_data !== 8'h0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
      #27; rst = 1'b0; #(4*Q);
   endtask

   task automatic test_write_read();
      logic a; int acks; int e0, e1; logic [7:0] r0, r1;
      wr_log.delete(); acks = 0;
      bus_start();
      send_byte(8'h44, a); if (a) acks++;
      send_byte(8'h03, a); if (a) acks++;
      send_byte(8'hA5, a); if (a) acks++;
      send_byte(8'h5A, a); if (a) acks++;
      checks++; if (sel !== 1'b1)  begin failures++; $display("FAIL wr_sel got=%b exp=1", sel); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", busy); end
      bus_stop(); #Q;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_after_stop got=%b exp=0", busy); end
      checks++; if (sel !== 1'b0)  begin failures++; $display("FAIL wr_sel_after_stop got=%b exp=0", sel); end
      checks++; if (acks != 4)     begin failures++; $display("FAIL wr_acks got=%0d exp=4", acks); end
      e0 = (wr_log.size() > 0) ? wr_log[0] : -1;
      e1 = (wr_log.size() > 1) ? wr_log[1] : -1;
      checks++; if (wr_log.size() != 2) begin failures++; $display("FAIL wr_stb_count got=%0d exp=2", wr_log.size()); end
      checks++; if (e0 != 'h3A5) begin failures++; $display("FAIL wr_stb_0 got=%0h exp=3a5", e0); end
      checks++; if (e1 != 'h45A) begin failures++; $display("FAIL wr_stb_1 got=%0h exp=45a", e1); end
      bus_start(); send_byte(8'h44, a); send_byte(8'h03, a); bus_stop();
      bus_start(); send_byte(8'h45, a);
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL rd_addr_ack got=%b exp=1", a); end
      recv_byte(1'b1, r0); recv_byte(1'b0, r1); bus_stop();
      checks++; if (r0 !== 8'hA5) begin failures++; $display("FAIL rd_byte0 got=%h exp=a5", r0); end
      checks++; if (r1 !== 8'h5A) begin failures++; $display("FAIL rd_byte1 got=%h exp=5a", r1); end
   endtask

   task automatic test_addr_mismatch();
      logic a, a2; logic [7:0] r0;
      wr_log.delete(); oe_seen = 1'b0;
      bus_start();
      send_byte(8'h60, a); send_byte(8'h03, a2); send_byte(8'hEE, a2);
      checks++; if (a !== 1'b0)       begin failures++; $display("FAIL mm_ack got=%b exp=0", a); end
      checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL mm_sda_driven got=%b exp=0", oe_seen); end
      checks++; if (sel !== 1'b0)     begin failures++; $display("FAIL mm_sel got=%b exp=0", sel); end
      checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL mm_busy got=%b exp=1", busy); end
      bus_stop(); #Q;
      checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL mm_busy_after_stop got=%b exp=0", busy); end
      checks++; if (wr_log.size() != 0) begin failures++; $display("FAIL mm_wr_stb got=%0d exp=0", wr_log.size()); end
      bus_start(); send_byte(8'h44, a); send_byte(8'h03, a);
      bus_start(); send_byte(8'h45, a); recv_byte(1'b0, r0); bus_stop();
      checks++; if (r0 !== 8'hA5) begin failures++; $display("FAIL mm_mem_unchanged got=%h exp=a5", r0); end
   endtask

   task automatic test_wrap();
      logic a; int acks; int e0, e1; logic [7:0] r0, r1;
      wr_log.delete();
      write_seq(8'h0F, 8'h11, 8'h22, 2, acks);
      e0 = (wr_log.size() > 0) ? wr_log[0] : -1;
      e1 = (wr_log.size() > 1) ? wr_log[1] : -1;
      checks++; if (acks != 4)   begin failures++; $display("FAIL wrap_acks got=%0d exp=4", acks); end
      checks++; if (e0 != 'hF11) begin failures++; $display("FAIL wrap_stb_0 got=%0h exp=f11", e0); end
      checks++; if (e1 != 'h022) begin failures++; $display("FAIL wrap_stb_1 got=%0h exp=22", e1); end
      bus_start(); send_byte(8'h44, a); send_byte(8'h0F, a);
      bus_start(); send_byte(8'h45, a); recv_byte(1'b1, r0); recv_byte(1'b0, r1); bus_stop();
      checks++; if (r0 !== 8'h11) begin failures++; $display("FAIL wrap_rd15 got=%h exp=11", r0); end
      checks++; if (r1 !== 8'h22) begin failures++; $display("FAIL wrap_rd0 got=%h exp=22", r1); end
   endtask

   task automatic test_rep_start_read();
      logic a; int acks; logic [7:0] r0, r1, r2;
      write_seq(8'h02, 8'h7E, 8'h00, 1, acks);
      bus_start(); send_byte(8'h44, a); send_byte(8'h02, a);
      bus_start(); send_byte(8'h45, a);
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL rs_addr_ack got=%b exp=1", a); end
      recv_byte(1'b1, r0); recv_byte(1'b0, r1); #Q;
      checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rs_release_after_nack got=%b exp=0", sda_oe); end
      bus_stop();
      bus_start(); send_byte(8'h45, a); recv_byte(1'b0, r2); bus_stop();
      checks++; if (r0 !== 8'h7E) begin failures++; $display("FAIL rs_byte0 got=%h exp=7e", r0); end
      checks++; if (r1 !== 8'hA5) begin failures++; $display("FAIL rs_byte1 got=%h exp=a5", r1); end
      checks++; if (r2 !== 8'h5A) begin failures++; $display("FAIL rs_ptr_persist got=%h exp=5a", r2); end
   endtask

   task automatic test_stop_mid_byte();
      logic a; int acks; logic [7:0] r0;
      write_seq(8'h06, 8'h66, 8'h77, 2, acks);
      wr_log.delete();
      bus_start(); send_byte(8'h44, a); send_byte(8'h06, a);
      send_bits(8'hA0, 4); bus_stop(); #Q;
      checks++; if (wr_log.size() != 0) begin failures++; $display("FAIL abort_wr_stb got=%0d exp=0", wr_log.size()); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
      checks++; if (sel !== 1'b0)  begin failures++; $display("FAIL abort_sel got=%b exp=0", sel); end
      bus_start(); send_byte(8'h45, a); recv_byte(1'b0, r0); bus_stop();
      checks++; if (r0 !== 8'h66) begin failures++; $display("FAIL abort_ptr_mem got=%h exp=66", r0); end
   endtask

   task automatic test_reset_mid_read();
      logic a; int acks; logic [7:0] r0, r1;
      write_seq(8'h00, 8'h3C, 8'h5C, 2, acks);
      bus_start(); send_byte(8'h44, a); send_byte(8'h00, a);
      bus_start(); send_byte(8'h45, a);
      checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL rst_drive_zero got=%b exp=1", sda_oe); end
      #2; rst = 1'b1; #1;
      checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rst_async_release got=%b exp=0", sda_oe); end
      #47; rst = 1'b0; #Q;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      bus_stop();
      bus_start(); send_byte(8'h45, a);
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL rst_addr_ack got=%b exp=1", a); end
      recv_byte(1'b1, r0); recv_byte(1'b0, r1); bus_stop();
      checks++; if (r0 !== 8'h00) begin failures++; $display("FAIL rst_mem0 got=%h exp=00", r0); end
      checks++; if (r1 !== 8'h00) begin failures++; $display("FAIL rst_mem1 got=%h exp=00", r1); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_addr_mismatch();
      test_wrap();
      test_rep_start_read();
      test_stop_mid_byte();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
